conv_window_gen: RTL and testbench

//  Upstream feeder of the 3x3x3 conv PE array. Takes a raster-order RGB pixel stream,

---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_window_gen_if.sv | 26 ++
 rtl/line_buffer.sv | 28 ++
 rtl/conv_window_gen.sv | 120 ++++++++++++
 tb/tb_conv_window_gen.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv window generator and the PE array:
// sample width, window geometry and the packed-window bit ordering.
package conv_pkg;

  localparam int PIX_W  = 8;
  localparam int NUM_CH = 3;
  localparam int KSZ    = 9;
  localparam int WIN_W  = NUM_CH * KSZ * PIX_W;

  // Indexed [ch][row][col]: ch 0 = R, row 0 = oldest line, col 0 = leftmost column.
  typedef logic [NUM_CH-1:0][2:0][2:0][PIX_W-1:0] win_arr_t;

  // R plane in the MSBs; within a plane k_0 (top-left) is at the MSBs, row-major.
  function automatic logic [WIN_W-1:0] pack_window(input win_arr_t w);
    logic [WIN_W-1:0] p;
    p = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int k = 0; k < KSZ; k++) begin
        p[WIN_W-1-(ch*KSZ+k)*PIX_W -: PIX_W] = w[2'(ch)][2'(k/3)][2'(k%3)];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out stream bus of the conv window generator.
interface conv_window_gen_if
  import conv_pkg::*;
#(
  parameter int PIX_W = conv_pkg::PIX_W
);

  logic [3*PIX_W-1:0]            pix_i;
  logic                          pix_valid_i;
  logic                          pix_ready_o;
  logic [NUM_CH*KSZ*PIX_W-1:0]   win_o;
  logic                          win_valid_o;
  logic                          win_ready_i;
  logic                          win_last_o;

  modport slave (
    input  pix_i, pix_valid_i, win_ready_i,
    output pix_ready_o, win_o, win_valid_o, win_last_o
  );

  modport master (
    output pix_i, pix_valid_i, win_ready_i,
    input  pix_ready_o, win_o, win_valid_o, win_last_o
  );

endinterface

// File: rtl/line_buffer.sv
// Simple dual-port line RAM with registered read; a read of the address
// being written returns the old contents.
module line_buffer #(
  parameter int DEPTH = 416,
  parameter int WIDTH = 24,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_window_gen.sv
// Raster RGB stream to 3x3x3 sliding windows (valid-only convolution),
// two cascaded line buffers and a 1-deep output register.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = 416,
  parameter int IMG_H = 416,
  parameter int PIX_W = conv_pkg::PIX_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  conv_window_gen_if.slave   bus
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int PXW = 3 * PIX_W;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  win_arr_t         sh_q, sh_d, sh_shift;
  logic [WIN_W-1:0] win_q, win_d;
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;

  logic [PXW-1:0]      lb_new_rd, lb_old_rd;
  logic [2:0][PXW-1:0] col_src;
  logic                accept, emit, at_last;

  assign bus.pix_ready_o = !win_valid_q || bus.win_ready_i;
  assign accept          = bus.pix_valid_i && bus.pix_ready_o;
  assign emit            = (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign at_last         = (row_q == ROW_MAX) && (col_q == COL_MAX);

  // Read address runs one pixel ahead so the RAM output already holds column col_q
  // when that pixel is accepted; it never collides with the write address.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PXW), .AW(CW)) u_lb_new (
    .clk_i   (clk_i),
    .we_i    (accept),
    .waddr_i (col_q),
    .wdata_i (bus.pix_i),
    .raddr_i (col_d),
    .rdata_o (lb_new_rd)
  );

  // Older line: takes over each column of the newer line as it is overwritten.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PXW), .AW(CW)) u_lb_old (
    .clk_i   (clk_i),
    .we_i    (accept),
    .waddr_i (col_q),
    .wdata_i (lb_new_rd),
    .raddr_i (col_d),
    .rdata_o (lb_old_rd)
  );

  assign col_src[0] = lb_old_rd;
  assign col_src[1] = lb_new_rd;
  assign col_src[2] = bus.pix_i;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    for (genvar gr = 0; gr < 3; gr++) begin : g_row
      assign sh_shift[gi][gr][0] = sh_q[gi][gr][1];
      assign sh_shift[gi][gr][1] = sh_q[gi][gr][2];
      assign sh_shift[gi][gr][2] = col_src[gr][PXW-1-gi*PIX_W -: PIX_W];
    end
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    sh_d        = sh_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;

    if (win_valid_q && bus.win_ready_i) begin
      win_valid_d = 1'b0;
    end

    if (accept) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      sh_d = sh_shift;
      if (emit) begin
        win_valid_d = 1'b1;
        win_d       = pack_window(sh_shift);
        win_last_d  = at_last;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q       <= '0;
      row_q       <= '0;
      sh_q        <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      sh_q        <= sh_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

  assign bus.win_o       = win_q;
  assign bus.win_valid_o = win_valid_q;
  assign bus.win_last_o  = win_last_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: 4x4 frames on one instance, a 6x3 frame on another,
// checked every cycle against a window model built from pixel coordinates.
module tb_conv_window_gen;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_window_gen_if #(.PIX_W(8)) bus_a ();
  conv_window_gen_if #(.PIX_W(8)) bus_b ();

  conv_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  conv_window_gen #(.IMG_W(6), .IMG_H(3), .PIX_W(8)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [216:0] qa[$], qb[$];
  logic [216:0] obs_a[$], obs_b[$];
  logic [216:0] ref1[4];
  bit           prev_valid_a = 1'b0;
  bit           lat_arm = 1'b0;
  int           acc10_cyc = -1;
  logic [215:0] first_win_lit;
  logic [215:0] mw;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Sample value of channel ch (0=R,1=G,2=B) at pixel (r,c) of a w-wide frame.
  function automatic logic [7:0] pval(input int w, input int r, input int c, input int ch);
    return 8'(w * r + c + 64 * ch);
  endfunction

  // Window ending at (r,c): planes R,G,B, each row-major from (r-2,c-2), first item in MSBs.
  function automatic logic [215:0] model_win(input int w, input int r, input int c);
    logic [215:0] v;
    v = '0;
    for (int ch = 0; ch < 3; ch++)
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          v = {v[207:0], pval(w, r - 2 + dr, c - 2 + dc, ch)};
    return v;
  endfunction

  task automatic push_model(input bit b, input int w, input int h);
    logic [216:0] item;
    for (int r = 2; r < h; r++) begin
      for (int c = 2; c < w; c++) begin
        item = {(r == h - 1) && (c == w - 1), model_win(w, r, c)};
        if (b) qb.push_back(item);
        else   qa.push_back(item);
      end
    end
  endtask

  // Checkers: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_win_valid_a", {255'd0, bus_a.win_valid_o}, 256'd0);
      check("rst_win_last_a",  {255'd0, bus_a.win_last_o}, 256'd0);
      check("rst_win_a",       {40'd0, bus_a.win_o}, 256'd0);
      prev_valid_a = 1'b0;
    end else begin
      check("pix_ready_a", {255'd0, bus_a.pix_ready_o},
            {255'd0, !bus_a.win_valid_o || bus_a.win_ready_i});
      if (bus_a.win_valid_o) begin
        if (qa.size() == 0) begin
          check("unexpected_win_a", {255'd0, bus_a.win_valid_o}, 256'd0);
        end else begin
          check("win_a", {39'd0, bus_a.win_last_o, bus_a.win_o}, {39'd0, qa[0]});
          if (bus_a.win_ready_i) begin
            obs_a.push_back({bus_a.win_last_o, bus_a.win_o});
            void'(qa.pop_front());
          end
        end
        if (lat_arm && !prev_valid_a) begin
          check("latency_a", 256'(cyc), 256'(acc10_cyc));
          lat_arm = 1'b0;
        end
      end
      prev_valid_a = bus_a.win_valid_o;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_win_valid_b", {255'd0, bus_b.win_valid_o}, 256'd0);
      check("rst_win_b",       {39'd0, bus_b.win_last_o, bus_b.win_o}, 256'd0);
    end else if (bus_b.win_valid_o) begin
      if (qb.size() == 0) begin
        check("unexpected_win_b", {255'd0, bus_b.win_valid_o}, 256'd0);
      end else begin
        check("win_b", {39'd0, bus_b.win_last_o, bus_b.win_o}, {39'd0, qb[0]});
        if (bus_b.win_ready_i) begin
          obs_b.push_back({bus_b.win_last_o, bus_b.win_o});
          void'(qb.pop_front());
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the pixel was accepted.
  task automatic push_pix(input bit b, input int w, input int idx, input bit rnd);
    int          r, c, guard;
    bit          rdy;
    logic [23:0] px;
    r  = idx / w;
    c  = idx % w;
    px = {pval(w, r, c, 0), pval(w, r, c, 1), pval(w, r, c, 2)};
    if (rnd) begin
      for (int k = 0; k < 8 && $urandom_range(1, 0) == 0; k++) begin
        if (b) bus_b.pix_valid_i = 1'b0;
        else   bus_a.pix_valid_i = 1'b0;
        @(posedge clk); #1;
      end
    end
    if (b) begin bus_b.pix_i = px; bus_b.pix_valid_i = 1'b1; end
    else   begin bus_a.pix_i = px; bus_a.pix_valid_i = 1'b1; end
    guard = 0;
    rdy   = 1'b0;
    while (!rdy && guard < 200) begin
      @(negedge clk);
      rdy = b ? bus_b.pix_ready_o : bus_a.pix_ready_o;
      @(posedge clk); #1;
      guard++;
    end
    if (!rdy) check("pix_accept_timeout", 256'd0, 256'd1);
    else if (!b && lat_arm && idx == 10) acc10_cyc = cyc;
    if (b) bus_b.pix_valid_i = 1'b0;
    else   bus_a.pix_valid_i = 1'b0;
  endtask

  task automatic send_frame(input bit b, input int w, input int h, input bit rnd);
    for (int i = 0; i < w * h; i++) push_pix(b, w, i, rnd);
  endtask

  task automatic drain(input bit b);
    int g;
    g = 0;
    while ((b ? qb.size() : qa.size()) != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check(b ? "drain_b" : "drain_a", 256'(b ? qb.size() : qa.size()), 256'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic stall5();
    int g;
    g = 0;
    while (!bus_a.win_valid_o && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("stall_wait", {255'd0, bus_a.win_valid_o}, 256'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_pix_ready", {255'd0, bus_a.pix_ready_o}, 256'd0);
      check("stall_hold", {40'd0, bus_a.win_o}, {40'd0, first_win_lit});
    end
    @(posedge clk); #1;
    bus_a.win_ready_i = 1'b1;
  endtask

  task automatic compare_ref(input string name, input int n);
    check({name, "_count"}, 256'(obs_a.size()), 256'(n));
    for (int i = 0; i < n && i < obs_a.size(); i++)
      check(name, {39'd0, obs_a[i]}, {39'd0, ref1[i % 4]});
  endtask

  initial begin
    rst               = 1'b1;
    bus_a.pix_i       = '0;
    bus_a.pix_valid_i = 1'b0;
    bus_a.win_ready_i = 1'b1;
    bus_b.pix_i       = '0;
    bus_b.pix_valid_i = 1'b0;
    bus_b.win_ready_i = 1'b1;
    first_win_lit = {72'h00_01_02_04_05_06_08_09_0A,
                     72'h40_41_42_44_45_46_48_49_4A,
                     72'h80_81_82_84_85_86_88_89_8A};
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    // Hand-computed pins on the model itself.
    mw = model_win(4, 2, 2);
    check("model_first", {40'd0, mw}, {40'd0, first_win_lit});
    mw = model_win(4, 3, 3);
    check("model_last_R", {184'd0, mw[215:144]}, {184'd0, 72'h05_06_07_09_0A_0B_0D_0E_0F});
    mw = model_win(6, 2, 5);
    check("model_w6_k8", {248'd0, mw[151:144]}, 256'd17);

    // 1: full frame, consumer always ready
    lat_arm = 1'b1;
    push_model(0, 4, 4);
    send_frame(0, 4, 4, 0);
    drain(0);
    check("t1_count", 256'(obs_a.size()), 256'd4);
    check("t1_latency_seen", {255'd0, lat_arm}, 256'd0);
    if (obs_a.size() == 4) begin
      check("t1_first", {40'd0, obs_a[0][215:0]}, {40'd0, first_win_lit});
      check("t1_last_flags", {252'd0, obs_a[3][216], obs_a[2][216], obs_a[1][216], obs_a[0][216]},
            256'b1000);
      check("t1_last_k8", {248'd0, obs_a[3][151:144]}, 256'd15);
      for (int i = 0; i < 4; i++) ref1[i] = obs_a[i];
    end else begin
      for (int i = 0; i < 4; i++) ref1[i] = {(i == 3), model_win(4, 2 + i / 2, 2 + i % 2)};
    end

    // 2: hold the first window for 5 cycles
    obs_a.delete();
    bus_a.win_ready_i = 1'b0;
    push_model(0, 4, 4);
    fork
      send_frame(0, 4, 4, 0);
      stall5();
    join
    drain(0);
    compare_ref("t2", 4);

    // 3: random gaps on pix_valid_i
    obs_a.delete();
    push_model(0, 4, 4);
    send_frame(0, 4, 4, 1);
    drain(0);
    compare_ref("t3", 4);

    // 4: two frames back-to-back
    obs_a.delete();
    push_model(0, 4, 4);
    push_model(0, 4, 4);
    send_frame(0, 4, 4, 0);
    send_frame(0, 4, 4, 0);
    drain(0);
    compare_ref("t4", 8);

    // 5: reset after 7 pixels, then replay
    obs_a.delete();
    for (int i = 0; i < 7; i++) push_pix(0, 4, i, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_no_early_win", 256'(obs_a.size()), 256'd0);
    push_model(0, 4, 4);
    send_frame(0, 4, 4, 0);
    drain(0);
    compare_ref("t5", 4);

    // 6: 6x3 frame on the second instance
    obs_b.delete();
    push_model(1, 6, 3);
    send_frame(1, 6, 3, 0);
    drain(1);
    check("t6_count", 256'(obs_b.size()), 256'd4);
    for (int i = 0; i < 4 && i < obs_b.size(); i++) begin
      check("t6_k8", {248'd0, obs_b[i][151:144]}, 256'(14 + i));
      check("t6_last", {255'd0, obs_b[i][216]}, {255'd0, i == 3});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
